up_req_tagger: RTL and testbench

Client-side front end for the upstream memory port of the TLP processor. Accepts 64-bit read/write requests from a single on-chip master and allocates 5-bit PCIe tags for reads from a 32-entry pool. Issues `up_read`/`up_write` pulses with flow control against `up_wait`, matches returning `up_ack`/`up_rxtag` completions to the originating client request, and retires reads that never complete with a timeout error.

---
 rtl/up_req_pkg.sv | 22 ++
 rtl/up_tag_pool.sv | 90 +++++++++
 rtl/up_req_tagger.sv | 131 +++++++++++++
 tb/tb_up_req_tagger.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/up_req_pkg.sv
// Shared constants and helpers for the upstream request tagger.
package up_req_pkg;

    localparam int unsigned TAG_W    = 5;
    localparam int unsigned NUM_TAGS = 32;
    localparam logic [1:0]  AGE_MAX     = 2'd3;
    localparam logic [2:0]  ERR_TIMEOUT = 3'b100;

    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [NUM_TAGS-1:0] tag_vec_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic tag_t lowest_set(input tag_vec_t v);
        tag_t idx;
        idx = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (v[i]) idx = tag_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/up_tag_pool.sv
// Read tag pool: allocation, completion matching, ageing and timeout retirement.
module up_tag_pool
    import up_req_pkg::*;
(
    input  logic             pcie_clk,
    input  logic             pcie_rst,
    input  logic             alloc,
    input  logic             ack,
    input  logic [TAG_W-1:0] ack_tag,
    input  logic             tick,
    output logic             tag_avail,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             ack_hit,
    output logic             retire,
    output logic [TAG_W-1:0] retire_tag,
    output logic [5:0]       outstanding
);

    tag_vec_t busy_q, busy_d;
    tag_vec_t stale_q, stale_d;
    tag_vec_t pend_q, pend_d;
    logic [NUM_TAGS-1:0][1:0] age_q, age_d;
    logic [5:0] out_q, out_d;
    tag_vec_t free_vec;

    assign free_vec  = ~busy_q & ~stale_q;
    assign tag_avail = |free_vec;
    assign alloc_tag = lowest_set(free_vec);

    // A completion always takes priority over a timeout retirement.
    assign ack_hit    = ack & busy_q[ack_tag];
    assign retire     = (|pend_q) & ~ack_hit;
    assign retire_tag = lowest_set(pend_q);

    assign outstanding = out_q;

    always_comb begin
        busy_d  = busy_q;
        stale_d = stale_q;
        pend_d  = pend_q;
        age_d   = age_q;

        if (tick) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (busy_q[i]) begin
                    if (age_q[i] == AGE_MAX) pend_d[i] = 1'b1;
                    else                     age_d[i]  = age_q[i] + 2'd1;
                end
            end
        end

        if (ack_hit) begin
            busy_d[ack_tag] = 1'b0;
            pend_d[ack_tag] = 1'b0;
        end else if (ack) begin
            stale_d[ack_tag] = 1'b0;
        end

        if (retire) begin
            busy_d[retire_tag]  = 1'b0;
            pend_d[retire_tag]  = 1'b0;
            stale_d[retire_tag] = 1'b1;
        end

        if (alloc) begin
            busy_d[alloc_tag] = 1'b1;
            pend_d[alloc_tag] = 1'b0;
            age_d[alloc_tag]  = '0;
        end

        out_d = out_q + 6'(alloc) - 6'(ack_hit | retire);
    end

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            busy_q  <= '0;
            stale_q <= '0;
            pend_q  <= '0;
            age_q   <= '0;
            out_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            stale_q <= stale_d;
            pend_q  <= pend_d;
            age_q   <= age_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: rtl/up_req_tagger.sv
// Client front end for the upstream memory port: accepts requests, tags reads,
// routes completions back to the client and times out reads that never complete.
module up_req_tagger
    import up_req_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 4096,
    parameter int unsigned ID_W        = 8
) (
    input  logic             pcie_clk,
    input  logic             pcie_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [ID_W-1:0]  req_id,
    input  logic [63:0]      req_address,
    input  logic [63:0]      req_wdata,
    output logic             up_read,
    output logic             up_write,
    output logic [TAG_W-1:0] up_txtag,
    output logic [63:0]      up_address,
    output logic [63:0]      up_writedata,
    input  logic             up_wait,
    input  logic             up_ack,
    input  logic [TAG_W-1:0] up_rxtag,
    input  logic [2:0]       up_err,
    input  logic [63:0]      up_readdata,
    output logic             rsp_valid,
    output logic [ID_W-1:0]  rsp_id,
    output logic [2:0]       rsp_err,
    output logic [63:0]      rsp_data,
    output logic [5:0]       outstanding,
    output logic [15:0]      spurious_cnt
);

    localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic             tag_avail;
    logic [TAG_W-1:0] alloc_tag;
    logic             ack_hit;
    logic             retire;
    logic [TAG_W-1:0] retire_tag;
    logic             accept;
    logic             alloc;
    logic             tick;

    logic [PRESC_W-1:0] presc_q;
    logic [ID_W-1:0]    id_ram [NUM_TAGS];

    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [2:0]      rsp_err_q;
    logic [63:0]     rsp_data_q;
    logic [15:0]     spur_q;

    // Outputs stay quiet while reset is held.
    assign req_ready = ~pcie_rst & ~up_wait & (req_write | tag_avail);
    assign accept    = req_valid & req_ready;
    assign up_read   = accept & ~req_write;
    assign up_write  = accept & req_write;
    assign alloc     = up_read;

    assign up_txtag     = req_write ? '0 : alloc_tag;
    assign up_address   = req_address;
    assign up_writedata = req_wdata;

    up_tag_pool u_pool (
        .pcie_clk    (pcie_clk),
        .pcie_rst    (pcie_rst),
        .alloc       (alloc),
        .ack         (up_ack),
        .ack_tag     (up_rxtag),
        .tick        (tick),
        .tag_avail   (tag_avail),
        .alloc_tag   (alloc_tag),
        .ack_hit     (ack_hit),
        .retire      (retire),
        .retire_tag  (retire_tag),
        .outstanding (outstanding)
    );

    assign tick = (presc_q == PRESC_W'(TICK_CYCLES - 1));

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (alloc) id_ram[alloc_tag] <= req_id;
    end

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_err_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= ack_hit | retire;
            if (ack_hit) begin
                rsp_id_q   <= id_ram[up_rxtag];
                rsp_err_q  <= up_err;
                rsp_data_q <= up_readdata;
            end else if (retire) begin
                rsp_id_q   <= id_ram[retire_tag];
                rsp_err_q  <= ERR_TIMEOUT;
                rsp_data_q <= '0;
            end
        end
    end

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            spur_q <= '0;
        end else if (up_ack && !ack_hit && spur_q != 16'hFFFF) begin
            spur_q <= spur_q + 16'd1;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_data     = rsp_data_q;
    assign spurious_cnt = spur_q;

endmodule

// File: tb/tb_up_req_tagger.sv
// Self-checking bench for up_req_tagger: directed scenarios plus random traffic
// against a tag-table reference model.
module tb_up_req_tagger;

    localparam int unsigned TICK = 16;
    localparam int unsigned IDW  = 8;

    logic        pcie_clk;
    logic        pcie_rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_id;
    logic [63:0] req_address;
    logic [63:0] req_wdata;
    logic        up_read;
    logic        up_write;
    logic [4:0]  up_txtag;
    logic [63:0] up_address;
    logic [63:0] up_writedata;
    logic        up_wait;
    logic        up_ack;
    logic [4:0]  up_rxtag;
    logic [2:0]  up_err;
    logic [63:0] up_readdata;
    logic        rsp_valid;
    logic [7:0]  rsp_id;
    logic [2:0]  rsp_err;
    logic [63:0] rsp_data;
    logic [5:0]  outstanding;
    logic [15:0] spurious_cnt;

    up_req_tagger #(
        .TICK_CYCLES (TICK),
        .ID_W        (IDW)
    ) dut (
        .pcie_clk     (pcie_clk),
        .pcie_rst     (pcie_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_id       (req_id),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .up_read      (up_read),
        .up_write     (up_write),
        .up_txtag     (up_txtag),
        .up_address   (up_address),
        .up_writedata (up_writedata),
        .up_wait      (up_wait),
        .up_ack       (up_ack),
        .up_rxtag     (up_rxtag),
        .up_err       (up_err),
        .up_readdata  (up_readdata),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_err      (rsp_err),
        .rsp_data     (rsp_data),
        .outstanding  (outstanding),
        .spurious_cnt (spurious_cnt)
    );

    initial pcie_clk = 1'b0;
    always #5 pcie_clk = ~pcie_clk;

    // Reference model: per-tag table, tick count since allocation, cycle index since reset.
    bit         m_busy  [32];
    bit         m_stale [32];
    int         m_ticks [32];
    logic [7:0] m_id    [32];
    int         m_cyc;
    int         m_spur;
    bit         e_valid;
    logic [7:0] e_id;
    logic [2:0] e_err;
    logic [63:0] e_data;

    int   n_checks;
    int   n_errors;
    logic [4:0] last_txtag;
    logic       last_ready;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_lowest_free();
        for (int t = 0; t < 32; t++) if (!m_busy[t] && !m_stale[t]) return t;
        return -1;
    endfunction

    // A read expires on the fourth tick after it was issued.
    function automatic int m_retire_cand();
        for (int t = 0; t < 32; t++) if (m_busy[t] && m_ticks[t] >= 4) return t;
        return -1;
    endfunction

    function automatic int m_count_busy();
        int n;
        n = 0;
        for (int t = 0; t < 32; t++) if (m_busy[t]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int t = 0; t < 32; t++) begin
            m_busy[t] = 0; m_stale[t] = 0; m_ticks[t] = 0; m_id[t] = '0;
        end
        m_cyc = 0; m_spur = 0; e_valid = 0;
    endtask

    task automatic drive_idle();
        req_valid = 0; req_write = 0; req_id = '0; req_address = '0; req_wdata = '0;
        up_wait = 0; up_ack = 0; up_rxtag = '0; up_err = '0; up_readdata = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
    task automatic step();
        int  lf, rc, rx;
        bit  hit, fire, exp_ready;
        @(negedge pcie_clk);
        lf = m_lowest_free();
        exp_ready = !up_wait && (req_write || lf >= 0);
        fire = req_valid && exp_ready;
        last_ready = req_ready;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("up_read", up_read, fire && !req_write);
        check_eq("up_write", up_write, fire && req_write);
        if (fire) begin
            last_txtag = up_txtag;
            check_eq("up_txtag", up_txtag, req_write ? 0 : lf);
            check_eq("up_address", up_address, req_address);
            check_eq("up_writedata", up_writedata, req_wdata);
        end
        rx  = int'(up_rxtag);
        hit = up_ack && m_busy[rx];
        rc  = m_retire_cand();
        e_valid = 0;
        if (hit) begin
            e_valid = 1; e_id = m_id[rx]; e_err = up_err; e_data = up_readdata;
            m_busy[rx] = 0;
        end else if (rc >= 0) begin
            e_valid = 1; e_id = m_id[rc]; e_err = 3'b100; e_data = '0;
            m_busy[rc] = 0; m_stale[rc] = 1;
        end
        if (up_ack && !hit) begin
            m_stale[rx] = 0;
            if (m_spur < 65535) m_spur++;
        end
        if (m_cyc % TICK == TICK - 1) begin
            for (int t = 0; t < 32; t++) if (m_busy[t] && m_ticks[t] < 4) m_ticks[t]++;
        end
        if (fire && !req_write) begin
            m_busy[lf] = 1; m_ticks[lf] = 0; m_id[lf] = req_id;
        end
        m_cyc++;
        @(posedge pcie_clk);
        #1;
        check_eq("rsp_valid", rsp_valid, e_valid);
        if (e_valid) begin
            check_eq("rsp_id", rsp_id, e_id);
            check_eq("rsp_err", rsp_err, e_err);
            check_eq("rsp_data", rsp_data, e_data);
        end
        check_eq("outstanding", outstanding, m_count_busy());
        check_eq("spurious_cnt", spurious_cnt, m_spur);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge pcie_clk);
        #1;
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_id", rsp_id, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_spurious", spurious_cnt, 0);
        model_reset();
        pcie_rst = 0;
    endtask

    task automatic apply_reset();
        pcie_rst = 1;
        drive_idle();
        release_reset();
    endtask

    task automatic do_read(input logic [7:0] id, input logic [63:0] addr);
        drive_idle();
        req_valid = 1; req_write = 0; req_id = id; req_address = addr;
        step();
        drive_idle();
    endtask

    task automatic do_ack(input int tag, input logic [2:0] err, input logic [63:0] data);
        drive_idle();
        up_ack = 1; up_rxtag = 5'(tag); up_err = err; up_readdata = data;
        step();
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, start, found;
        n_checks = 0; n_errors = 0;
        last_txtag = '0; last_ready = 0;
        model_reset();
        pcie_rst = 1;
        drive_idle();
        release_reset();

        // Read round trip
        do_read(8'h11, 64'h1000);
        check_eq("rt_tag", last_txtag, 0);
        do_ack(0, 3'd0, 64'hDEADBEEF_CAFEF00D);
        check_eq("rt_rsp_valid", rsp_valid, 1);
        check_eq("rt_rsp_id", rsp_id, 8'h11);
        check_eq("rt_rsp_data", rsp_data, 64'hDEADBEEF_CAFEF00D);
        check_eq("rt_outstanding", outstanding, 0);

        // Pool exhaustion
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            do_read(8'(i + 8'h40), 64'(i * 64));
            check_eq("exh_tag", last_txtag, i);
        end
        check_eq("exh_outstanding", outstanding, 32);
        do_read(8'hAA, 64'h2000);
        check_eq("exh_read_blocked", last_ready, 0);
        drive_idle();
        req_valid = 1; req_write = 1; req_address = 64'h3000; req_wdata = 64'h1234;
        step();
        check_eq("exh_write_ready", last_ready, 1);
        check_eq("exh_write_tag", last_txtag, 0);
        do_ack(7, 3'd2, 64'h77);
        do_read(8'hBB, 64'h4000);
        check_eq("exh_reuse_tag", last_txtag, 7);

        // Backpressure
        apply_reset();
        drive_idle();
        req_valid = 1; req_id = 8'h21; up_wait = 1;
        step();
        check_eq("bp_ready", last_ready, 0);
        check_eq("bp_outstanding", outstanding, 0);

        // Timeout, stale tag, late ack
        apply_reset();
        do_read(8'h33, 64'h5000);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (rsp_valid) begin lat = i; break; end
        end
        check_eq("to_in_window", (lat >= 48 && lat <= 66), 1);
        check_eq("to_err", rsp_err, 3'b100);
        check_eq("to_id", rsp_id, 8'h33);
        do_read(8'h34, 64'h5100);
        check_eq("to_stale_skipped", last_txtag, 1);
        do_ack(0, 3'd0, 64'h99);
        check_eq("to_late_no_rsp", rsp_valid, 0);
        check_eq("to_spurious", spurious_cnt, 1);
        do_read(8'h35, 64'h5200);
        check_eq("to_tag_reused", last_txtag, 0);

        // Ack colliding with a timeout retirement
        apply_reset();
        for (int i = 0; i < 6; i++) do_read(8'(8'h50 + i), 64'h6000);
        do_ack(3, 3'd0, 64'h1);
        repeat (20) step();
        do_read(8'h63, 64'h6100);
        check_eq("col_realloc", last_txtag, 3);
        do_ack(0, 3'd0, 64'h2);
        do_ack(1, 3'd0, 64'h3);
        do_ack(2, 3'd0, 64'h4);
        do_ack(4, 3'd0, 64'h5);
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_retire_cand() == 5) begin found = 1; break; end
            step();
        end
        check_eq("col_reached", found, 1);
        do_ack(3, 3'd1, 64'hABCD);
        check_eq("col_first_id", rsp_id, 8'h63);
        check_eq("col_first_err", rsp_err, 3'd1);
        step();
        check_eq("col_second_valid", rsp_valid, 1);
        check_eq("col_second_id", rsp_id, 8'h55);
        check_eq("col_second_err", rsp_err, 3'b100);

        // Reset mid-flight
        apply_reset();
        for (int i = 0; i < 4; i++) do_read(8'(8'h70 + i), 64'h7000);
        check_eq("mf_outstanding", outstanding, 4);
        req_valid = 1; req_write = 0;
        #2;
        pcie_rst = 1;
        #1;
        check_eq("mf_ready_in_rst", req_ready, 0);
        check_eq("mf_read_in_rst", up_read, 0);
        check_eq("mf_outstanding_rst", outstanding, 0);
        check_eq("mf_rsp_valid_rst", rsp_valid, 0);
        drive_idle();
        release_reset();
        do_read(8'h80, 64'h8000);
        check_eq("mf_first_tag", last_txtag, 0);

        // Random traffic
        apply_reset();
        start = 0;
        for (int c = 0; c < 4000; c++) begin
            drive_idle();
            req_valid   = ($urandom_range(0, 99) < 50);
            req_write   = ($urandom_range(0, 99) < 30);
            req_id      = 8'($urandom);
            req_address = {$urandom, $urandom};
            req_wdata   = {$urandom, $urandom};
            up_wait     = ($urandom_range(0, 99) < 20);
            up_ack      = ($urandom_range(0, 99) < 35);
            up_rxtag    = 5'($urandom);
            up_err      = ($urandom_range(0, 99) < 80) ? 3'd0 : 3'($urandom);
            up_readdata = {$urandom, $urandom};
            if (up_ack && $urandom_range(0, 99) < 75) begin
                start = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++) begin
                    if (m_busy[(start + k) % 32]) begin
                        up_rxtag = 5'((start + k) % 32);
                        break;
                    end
                end
            end
            step();
        end
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
